humansized_muldiv_seq: RTL and testbench
========================================

HUMANSIZED_MULDIV_SEQ -- requirements
Module: humansized_muldiv_seq

Interface
REQ-001 Parameter: W, 8, operand width in bits (W >= 2).
REQ-002 clk  input  1  rising-edge clock; the only clock.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 start  input  1  request a new operation; accepted only in IDLE.
REQ-005 fn  input  2  operation: 00 MULU, 01 MULS, 10 DIVU, 11 reserved.
REQ-006 a  input  W  multiplier (MUL) or dividend (DIV).
REQ-007 b  input  W  multiplicand (MUL) or divisor (DIV).
REQ-008 busy  output  1  high in every state except IDLE.
REQ-009 done  output  1  one-cycle pulse; res_hi and res_lo are valid from this cycle.
REQ-010 res_hi, res_lo  output  W each  product {hi,lo}, or remainder (hi) and quotient (lo).
REQ-011 dp_op  output  5  datapath op: bit0 load, bits2:1 shift type, bits4:3 add type.
REQ-012 dp_di, dp_ci  output  W, 1  datapath operand and carry-in.
REQ-013 dp_pm  input  2W  datapath {P,M} register contents.

Function
REQ-014 States: IDLE, LOAD, STEP_A, STEP_B, DONE; a step counter counts 0..W-1.
REQ-015 IDLE with start=1: capture a, b and fn; go to LOAD. IDLE with start=0: stay in IDLE.
REQ-016 LOAD: dp_op=00001, dp_di=a, dp_ci=0; go to STEP_A.
REQ-017 MULU steps:
- STEP_A: dp_op=00000, dp_di=b, dp_ci=0.
- STEP_B: dp_op=00010 (shift right logical).
REQ-018 DIVU steps:
- STEP_A: dp_op=00110 (shift left).
- STEP_B: dp_op=10000, dp_di=~b, dp_ci=1 (trial subtract; the datapath suppresses the write on borrow).
REQ-019 From STEP_B, go to STEP_A if counter < W-1; otherwise go to DONE. Each pass through STEP_B increments the counter.
REQ-020 DONE: capture res_hi = dp_pm[2W-1:W] and res_lo = dp_pm[W-1:0] at the exiting edge; go to IDLE.
REQ-021 Timing: done is high in the first IDLE cycle after DONE. With start in cycle 0, done is high in cycle 2W+3 (cycle 19 for W=8).
REQ-022 Results hold their values until the next done pulse.
REQ-023 In IDLE and DONE, drive dp_op=00001, dp_di=0, dp_ci=0.
REQ-024 start while busy: ignore it, with no effect on the operation in progress.
REQ-025 start in the done cycle: accept it (back-to-back operation).
REQ-026 Divide by zero: quotient = all ones, remainder = dividend, with no special casing.
REQ-027 fn=11: execute as DIVU.

Reset
REQ-028 rst=1 at any clock edge (including mid-operation) forces:
- state IDLE, counter 0, busy=0, done=0;
- res_hi=res_lo=0;
- dp_op=00001, dp_di=0.
REQ-029 A start asserted in the same cycle as rst is discarded.

Configuration
REQ-030 Macro HUMANSIZED_MULDIV_SIGNED_EN defined: MULS is supported. The product is two's-complement a*b.
- STEP_A: dp_op=01000, dp_di=b, dp_ci=0, except the final step, which uses dp_di=~b, dp_ci=1.
- STEP_B: dp_op=00100 (shift right arithmetic).
REQ-031 Macro HUMANSIZED_MULDIV_SIGNED_EN undefined: fn=01 executes as MULU, and no signed-step logic is synthesised.

Structure
REQ-032 Package humansized_muldiv_pkg holds:
- the dp_op constants OP_LOAD, OP_ADDU, OP_ADDS, OP_SRL, OP_SRA, OP_SHL, OP_TRIAL;
- the fn encodings;
- the state enum.
REQ-033 Sub-module humansized_muldiv_opgen is purely combinational. It maps (state, fn, last-step flag, b) to dp_op, dp_di and dp_ci.
REQ-034 The sequencer registers only state, counter, captured operands and results.

Verification (bench pairs the block with the datapath, W=8)
REQ-035 MULU a=0xFF, b=0xFF, start at cycle 0 -> done at cycle 19, {res_hi,res_lo}=0xFE01.
REQ-036 DIVU a=100, b=7 -> res_lo=14, res_hi=2.
REQ-037 DIVU a=0x5A, b=0 -> res_lo=0xFF, res_hi=0x5A.
REQ-038 Macro defined, MULS a=0xFD, b=0x05 -> {res_hi,res_lo}=0xFFF1. Macro undefined, same inputs -> 0x04F1.
REQ-039 Reset test: MULU 3*5, assert rst at cycle 7, then run DIVU 9/2. Required response:
- busy=0 at cycle 8, with no done pulse;
- the DIVU yields res_lo=4, res_hi=1.
REQ-040 Handshake test: pulse start twice during an operation, then assert start in the done cycle. Required response:
- the extra starts are ignored;
- the second operation completes exactly 2W+3 cycles later.

Source files
------------

// File: rtl/humansized_muldiv_pkg.sv
// Shared constants for the sequential multiply/divide sequencer: datapath op codes,
// function encodings and the sequencer state enum.
package humansized_muldiv_pkg;

  // dp_op fields: bit0 load, bits2:1 shift type, bits4:3 add type.
  localparam logic [4:0] OP_LOAD  = 5'b00001;
  localparam logic [4:0] OP_ADDU  = 5'b00000;
  localparam logic [4:0] OP_ADDS  = 5'b01000;
  localparam logic [4:0] OP_SRL   = 5'b00010;
  localparam logic [4:0] OP_SRA   = 5'b00100;
  localparam logic [4:0] OP_SHL   = 5'b00110;
  localparam logic [4:0] OP_TRIAL = 5'b10000;

  localparam logic [1:0] FN_MULU = 2'b00;
  localparam logic [1:0] FN_MULS = 2'b01;
  localparam logic [1:0] FN_DIVU = 2'b10;
  localparam logic [1:0] FN_RSVD = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_STEP_A = 3'd2,
    ST_STEP_B = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

endpackage

// File: rtl/humansized_muldiv_opgen.sv
// Combinational datapath-command generator: (state, fn, last step, b) -> dp_op/dp_di/dp_ci.
// Signed multiply steps exist only when HUMANSIZED_MULDIV_SIGNED_EN is defined.
module humansized_muldiv_opgen
  import humansized_muldiv_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [2:0]   state_i,
  input  logic [1:0]   fn_i,
  input  logic         last_i,
  input  logic [W-1:0] b_i,
  output logic [4:0]   dp_op_o,
  output logic [W-1:0] dp_di_o,
  output logic         dp_ci_o
);

  state_e st;
  logic   is_div;

  assign st     = state_e'(state_i);
  // Reserved fn=11 shares the divide path.
  assign is_div = fn_i[1];

`ifndef HUMANSIZED_MULDIV_SIGNED_EN
  logic unused_sig;
  assign unused_sig = ^{last_i, fn_i[0]};
`endif

  always_comb begin
    dp_op_o = OP_LOAD;
    dp_di_o = '0;
    dp_ci_o = 1'b0;
    case (st)
      ST_STEP_A: begin
        if (is_div) begin
          dp_op_o = OP_SHL;
        end
`ifdef HUMANSIZED_MULDIV_SIGNED_EN
        else if (fn_i == FN_MULS) begin
          // Multiplier MSB carries weight -2^(W-1): last step subtracts b.
          dp_op_o = OP_ADDS;
          if (last_i) begin
            dp_di_o = ~b_i;
            dp_ci_o = 1'b1;
          end else begin
            dp_di_o = b_i;
          end
        end
`endif
        else begin
          dp_op_o = OP_ADDU;
          dp_di_o = b_i;
        end
      end
      ST_STEP_B: begin
        if (is_div) begin
          dp_op_o = OP_TRIAL;
          dp_di_o = ~b_i;
          dp_ci_o = 1'b1;
        end
`ifdef HUMANSIZED_MULDIV_SIGNED_EN
        else if (fn_i == FN_MULS) begin
          dp_op_o = OP_SRA;
        end
`endif
        else begin
          dp_op_o = OP_SRL;
        end
      end
      default: begin
        dp_op_o = OP_LOAD;
      end
    endcase
  end

endmodule

// File: rtl/humansized_muldiv_seq.sv
// Sequencer for a shift/add multiply and restoring divide on an external {P,M} datapath.
// Optional signed multiply via HUMANSIZED_MULDIV_SIGNED_EN (see humansized_muldiv_opgen).
module humansized_muldiv_seq
  import humansized_muldiv_pkg::*;
#(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [1:0]     fn,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [W-1:0]   res_hi,
  output logic [W-1:0]   res_lo,
  output logic [4:0]     dp_op,
  output logic [W-1:0]   dp_di,
  output logic           dp_ci,
  input  logic [2*W-1:0] dp_pm,
  output logic [2:0]     dbg_state_o
);

  localparam int CW = (W > 2) ? $clog2(W) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic [1:0]    fn_q, fn_d;
  logic [W-1:0]  res_hi_q, res_hi_d;
  logic [W-1:0]  res_lo_q, res_lo_d;
  logic          done_q, done_d;
  logic          last_step;
  logic [W-1:0]  gen_di;

  assign last_step = (cnt_q == CNT_LAST);

  // Handshake: start is a request taken only while busy is low (IDLE, which
  // includes the done cycle); a request seen while busy is dropped, not queued.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    fn_d     = fn_q;
    res_hi_d = res_hi_q;
    res_lo_d = res_lo_q;
    done_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (start) begin
          a_d     = a;
          b_d     = b;
          fn_d    = fn;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        cnt_d   = '0;
        state_d = ST_STEP_A;
      end
      ST_STEP_A: begin
        state_d = ST_STEP_B;
      end
      ST_STEP_B: begin
        cnt_d   = cnt_q + CNT_ONE;
        state_d = last_step ? ST_DONE : ST_STEP_A;
      end
      ST_DONE: begin
        res_hi_d = dp_pm[2*W-1:W];
        res_lo_d = dp_pm[W-1:0];
        done_d   = 1'b1;
        state_d  = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      fn_q     <= FN_MULU;
      res_hi_q <= '0;
      res_lo_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      fn_q     <= fn_d;
      res_hi_q <= res_hi_d;
      res_lo_q <= res_lo_d;
      done_q   <= done_d;
    end
  end

  humansized_muldiv_opgen #(.W(W)) u_opgen (
    .state_i (state_q),
    .fn_i    (fn_q),
    .last_i  (last_step),
    .b_i     (b_q),
    .dp_op_o (dp_op),
    .dp_di_o (gen_di),
    .dp_ci_o (dp_ci)
  );

  // The load operand is the captured dividend/multiplier, which opgen never sees.
  assign dp_di       = (state_q == ST_LOAD) ? a_q : gen_di;
  assign busy        = (state_q != ST_IDLE);
  assign done        = done_q;
  assign res_hi      = res_hi_q;
  assign res_lo      = res_lo_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_humansized_muldiv_seq.sv
// Directed bench: sequencer paired with a behavioural {P,M} datapath, W=8.
// Expected signed-multiply results follow HUMANSIZED_MULDIV_SIGNED_EN.
module tb_humansized_muldiv_seq;

  localparam int W = 8;

  logic           clk;
  logic           rst;
  logic           start;
  logic [1:0]     fn;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           busy;
  logic           done;
  logic [W-1:0]   res_hi;
  logic [W-1:0]   res_lo;
  logic [4:0]     dp_op;
  logic [W-1:0]   dp_di;
  logic           dp_ci;
  logic [2*W-1:0] dp_pm;
  logic [2:0]     dbg_state;

  int n_tests = 0;
  int n_fail  = 0;

  humansized_muldiv_seq #(.W(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .fn          (fn),
    .a           (a),
    .b           (b),
    .busy        (busy),
    .done        (done),
    .res_hi      (res_hi),
    .res_lo      (res_lo),
    .dp_op       (dp_op),
    .dp_di       (dp_di),
    .dp_ci       (dp_ci),
    .dp_pm       (dp_pm),
    .dbg_state_o (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // behavioural datapath: P (high), M (low), plus one carry/extension bit
  logic [W-1:0] p_r, m_r;
  logic         c_r;
  wire  [W:0]   addu_s  = {1'b0, p_r} + {1'b0, dp_di} + {{W{1'b0}}, dp_ci};
  wire  [W:0]   adds_s  = {p_r[W-1], p_r} + {dp_di[W-1], dp_di} + {{W{1'b0}}, dp_ci};
  wire  [W+1:0] trial_t = {1'b0, c_r, p_r} + {2'b00, dp_di} + {{(W+1){1'b0}}, dp_ci};

  assign dp_pm = {p_r, m_r};

  always @(posedge clk) begin
    case (dp_op)
      5'b00001: begin p_r <= '0; m_r <= dp_di; c_r <= 1'b0; end
      5'b00000: if (m_r[0]) {c_r, p_r} <= addu_s; else c_r <= 1'b0;
      5'b01000: if (m_r[0]) {c_r, p_r} <= adds_s; else c_r <= p_r[W-1];
      5'b00010, 5'b00100: {p_r, m_r} <= {c_r, p_r, m_r[W-1:1]};
      5'b00110: {c_r, p_r, m_r} <= {p_r, m_r, 1'b0};
      5'b10000: begin
        c_r <= 1'b0;
        if (trial_t[W+1:W] != 2'b00) begin
          p_r    <= trial_t[W-1:0];
          m_r[0] <= 1'b1;
        end
      end
      default: ;
    endcase
  end

  // driver / checker tasks
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with the DUT idle (cycle 0); returns at the negedge of cycle 1.
  task automatic issue(input logic [1:0] f, input logic [W-1:0] x, input logic [W-1:0] y);
    start = 1'b1;
    fn    = f;
    a     = x;
    b     = y;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int c0, input int exp_cyc);
    int c;
    c = c0;
    while (done !== 1'b1 && c < 200) begin
      @(negedge clk);
      c++;
    end
    check(tag, c, exp_cyc);
  endtask

  initial begin
    logic saw_done;
    rst   = 1'b1;
    start = 1'b1;
    fn    = 2'b00;
    a     = 8'h12;
    b     = 8'h34;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_res", {res_hi, res_lo}, 16'h0000);
    check("rst_dp_op", dp_op, 5'b00001);
    check("rst_dp_di", dp_di, 8'h00);
    rst   = 1'b0;
    start = 1'b0;
    @(negedge clk);
    check("rst_start_discarded", busy, 1'b0);

    // MULU 0xFF * 0xFF
    issue(2'b00, 8'hFF, 8'hFF);
    check("mulu_c1_busy", busy, 1'b1);
    check("mulu_c1_op", dp_op, 5'b00001);
    check("mulu_c1_di", dp_di, 8'hFF);
    @(negedge clk);
    check("mulu_c2_op", dp_op, 5'b00000);
    check("mulu_c2_di", dp_di, 8'hFF);
    @(negedge clk);
    check("mulu_c3_op", dp_op, 5'b00010);
    wait_done("mulu_latency", 3, 19);
    check("mulu_res", {res_hi, res_lo}, 16'hFE01);
    check("mulu_done_not_busy", busy, 1'b0);
    @(negedge clk);
    check("mulu_done_one_cycle", done, 1'b0);
    check("mulu_res_hold", {res_hi, res_lo}, 16'hFE01);
    check("idle_dp_op", dp_op, 5'b00001);
    check("idle_dp_di", dp_di, 8'h00);

    // DIVU 100 / 7
    issue(2'b10, 8'd100, 8'd7);
    @(negedge clk);
    check("divu_c2_op", dp_op, 5'b00110);
    @(negedge clk);
    check("divu_c3_op", dp_op, 5'b10000);
    check("divu_c3_di", dp_di, 8'hF8);
    check("divu_c3_ci", dp_ci, 1'b1);
    wait_done("divu_latency", 3, 19);
    check("divu_res", {res_hi, res_lo}, 16'h020E);

    // DIVU by zero
    @(negedge clk);
    issue(2'b10, 8'h5A, 8'h00);
    wait_done("div0_latency", 1, 19);
    check("div0_res", {res_hi, res_lo}, 16'h5AFF);

    // fn=01 with signed operands
    @(negedge clk);
    issue(2'b01, 8'hFD, 8'h05);
    @(negedge clk);
`ifdef HUMANSIZED_MULDIV_SIGNED_EN
    check("muls_c2_op", dp_op, 5'b01000);
    @(negedge clk);
    check("muls_c3_op", dp_op, 5'b00100);
    repeat (13) @(negedge clk);
    check("muls_last_di", dp_di, 8'hFA);
    check("muls_last_ci", dp_ci, 1'b1);
    wait_done("muls_latency", 16, 19);
    check("muls_res", {res_hi, res_lo}, 16'hFFF1);
`else
    check("muls_c2_op", dp_op, 5'b00000);
    @(negedge clk);
    check("muls_c3_op", dp_op, 5'b00010);
    repeat (13) @(negedge clk);
    check("muls_last_di", dp_di, 8'h05);
    check("muls_last_ci", dp_ci, 1'b0);
    wait_done("muls_latency", 16, 19);
    check("muls_res", {res_hi, res_lo}, 16'h04F1);
`endif

    // reserved fn behaves as DIVU
    @(negedge clk);
    issue(2'b11, 8'd100, 8'd7);
    wait_done("rsvd_latency", 1, 19);
    check("rsvd_res", {res_hi, res_lo}, 16'h020E);

    // reset mid-operation
    @(negedge clk);
    issue(2'b00, 8'd3, 8'd5);
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_busy", busy, 1'b0);
    check("midrst_done", done, 1'b0);
    check("midrst_res", {res_hi, res_lo}, 16'h0000);
    check("midrst_dp_op", dp_op, 5'b00001);
    saw_done = 1'b0;
    repeat (25) begin
      @(negedge clk);
      if (done === 1'b1) saw_done = 1'b1;
    end
    check("midrst_no_done", saw_done, 1'b0);
    issue(2'b10, 8'd9, 8'd2);
    wait_done("postrst_latency", 1, 19);
    check("postrst_res", {res_hi, res_lo}, 16'h0104);

    // stray starts while busy, then back-to-back start in the done cycle
    @(negedge clk);
    issue(2'b00, 8'd3, 8'd5);
    repeat (3) @(negedge clk);
    start = 1'b1;
    fn    = 2'b10;
    a     = 8'd9;
    b     = 8'd2;
    @(negedge clk);
    start = 1'b0;
    check("hs_busy_c5", busy, 1'b1);
    repeat (5) @(negedge clk);
    start = 1'b1;
    fn    = 2'b01;
    a     = 8'hAA;
    b     = 8'h55;
    @(negedge clk);
    start = 1'b0;
    wait_done("hs_latency1", 11, 19);
    check("hs_res1", {res_hi, res_lo}, 16'h000F);
    issue(2'b10, 8'd100, 8'd7);
    check("hs_b2b_busy", busy, 1'b1);
    check("hs_b2b_done_low", done, 1'b0);
    check("hs_b2b_hold", {res_hi, res_lo}, 16'h000F);
    wait_done("hs_latency2", 1, 19);
    check("hs_res2", {res_hi, res_lo}, 16'h020E);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
